// File: rtl/rf_out_port.sv
// rf_out_port: diverts write-back writes to OUT_ADDR into a first-word-fall-through stream FIFO.
// Define RF_OUT_STATS_EN to add saturating word_cnt (pops) and stall_cnt (stall cycles) outputs.
module rf_out_port #(
  parameter int unsigned WIDTH_ADDR   = 4,
  parameter int unsigned WIDTH_VECTOR = 8,
  parameter int unsigned N            = 32,
  parameter int unsigned WA_FIFO      = 4,
  parameter int unsigned OUT_ADDR     = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [WIDTH_VECTOR-1:0]   wec,
  input  logic [WIDTH_ADDR-1:0]     addrc,
  input  logic [WIDTH_VECTOR*N-1:0] wdata_c,
  output logic                      stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH_VECTOR*N-1:0] out_data,
  output logic [WIDTH_VECTOR-1:0]   out_lane_mask,
  output logic                      fifo_full,
  output logic                      fifo_empty,
`ifdef RF_OUT_STATS_EN
  output logic [WA_FIFO:0]          fifo_count,
  output logic [31:0]               word_cnt,
  output logic [31:0]               stall_cnt
`else
  output logic [WA_FIFO:0]          fifo_count
`endif
);

  localparam int unsigned W_DATA = WIDTH_VECTOR * N;
  localparam int unsigned DEPTH  = 1 << WA_FIFO;
  localparam int unsigned W_CNT  = WA_FIFO + 1;

  typedef struct packed {
    logic [WIDTH_VECTOR-1:0] mask;
    logic [W_DATA-1:0]       data;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [WA_FIFO-1:0] r_wr_ptr;
  logic [WA_FIFO-1:0] r_rd_ptr;
  logic [W_CNT-1:0]   r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_push_req;
  logic   w_pop;
  logic   w_push;
  logic   w_stall;
  entry_t w_entry;
  entry_t w_head;

  assign w_full     = (r_count == W_CNT'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = (wec != '0) && (addrc == WIDTH_ADDR'(OUT_ADDR));
  assign w_pop      = !w_empty && out_ready;
  // A pop on a full FIFO frees the slot for a push in the same cycle.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_stall    = w_push_req && w_full && !w_pop;

  // Disabled lanes are stored as zero; the enable vector travels with the word.
  always_comb begin
    w_entry.mask = wec;
    w_entry.data = '0;
    for (int unsigned i = 0; i < WIDTH_VECTOR; i++) begin
      if (wec[i]) w_entry.data[i*N +: N] = wdata_c[i*N +: N];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + WA_FIFO'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + WA_FIFO'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + W_CNT'(1);
        2'b01:   r_count <= r_count - W_CNT'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale memory is masked whenever the FIFO is empty.
  assign w_head        = r_mem[r_rd_ptr];
  assign stall         = w_stall;
  assign out_valid     = !w_empty;
  assign out_data      = w_empty ? '0 : w_head.data;
  assign out_lane_mask = w_empty ? '0 : w_head.mask;
  assign fifo_full     = w_full;
  assign fifo_empty    = w_empty;
  assign fifo_count    = r_count;

`ifdef RF_OUT_STATS_EN
  logic [31:0] r_word_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_word_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_word_cnt != '1))    r_word_cnt  <= r_word_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign word_cnt  = r_word_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
